// File: rtl/demux8_1_buffered.sv
// Steers one source word to one of eight channel holding registers. Each channel
// has a valid/ready handshake and can either stall the producer or be overwritten.
module demux8_1_buffered #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          STRICT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     din,
  input  logic [2:0]           sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [8*WIDTH-1:0]   dout,
  output logic [7:0]           out_valid,
  input  logic [7:0]           out_ready,
  output logic [7:0]           overrun,
  input  logic [7:0]           clr_ovr,
  output logic [15:0]          accept_cnt
);

  logic [WIDTH-1:0] data_q [8];
  logic [7:0]       valid_q, valid_d;
  logic [7:0]       ovr_q, ovr_d;
  logic [15:0]      cnt_q;
  logic             accept;
  logic [7:0]       load;

  // in_ready must never depend on in_valid to avoid a handshake loop
  always_comb begin
    if (STRICT) begin
      in_ready = ~valid_q[sel] | out_ready[sel];
    end else begin
      in_ready = 1'b1;
    end
  end

  assign accept = in_valid & in_ready;
  assign load   = accept ? (8'b1 << sel) : 8'b0;

  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < 8; i++) begin
      if (load[i]) begin
        valid_d[i] = 1'b1;
      end else if (valid_q[i] && out_ready[i]) begin
        valid_d[i] = 1'b0;
      end
    end
  end

  // Set beats clear when both happen in the same cycle
  always_comb begin
    if (STRICT) begin
      ovr_d = 8'h00;
    end else begin
      ovr_d = (ovr_q & ~clr_ovr) | (load & valid_q & ~out_ready);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        data_q[i] <= '0;
      end
      valid_q <= 8'h00;
      ovr_q   <= 8'h00;
      cnt_q   <= 16'h0000;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (load[i]) begin
          data_q[i] <= din;
        end
      end
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      if (accept) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < 8; i++) begin
      dout[i*WIDTH +: WIDTH] = data_q[i];
    end
  end

  assign out_valid  = valid_q;
  assign overrun    = ovr_q;
  assign accept_cnt = cnt_q;

endmodule

// File: tb/tb_demux8_1_buffered.sv
// Checks a stalling (STRICT=1) and an overwriting (STRICT=0) instance against a
// per-channel behavioural model, with directed cases followed by random traffic.
module tb_demux8_1_buffered;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [W-1:0]   din;
  logic [2:0]     sel;
  logic           in_valid;
  logic [7:0]     out_ready;
  logic [7:0]     clr_ovr;

  logic           rdy_s, rdy_l;
  logic [8*W-1:0] dout_s, dout_l;
  logic [7:0]     ov_s, ov_l, ovr_s, ovr_l;
  logic [15:0]    cnt_s, cnt_l;

  demux8_1_buffered #(.WIDTH(W), .STRICT(1'b1)) u_strict (
    .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .in_valid(in_valid),
    .in_ready(rdy_s), .dout(dout_s), .out_valid(ov_s), .out_ready(out_ready),
    .overrun(ovr_s), .clr_ovr(clr_ovr), .accept_cnt(cnt_s)
  );

  demux8_1_buffered #(.WIDTH(W), .STRICT(1'b0)) u_loose (
    .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .in_valid(in_valid),
    .in_ready(rdy_l), .dout(dout_l), .out_valid(ov_l), .out_ready(out_ready),
    .overrun(ovr_l), .clr_ovr(clr_ovr), .accept_cnt(cnt_l)
  );

  // Model: index 0 = strict instance, 1 = overwriting instance
  logic [W-1:0] m_data  [2][8];
  bit           m_valid [2][8];
  bit           m_ovr   [2][8];
  int unsigned  m_cnt   [2];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [8*W-1:0] got, input logic [8*W-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) begin
        m_data[d][i]  = '0;
        m_valid[d][i] = 1'b0;
        m_ovr[d][i]   = 1'b0;
      end
      m_cnt[d] = 0;
    end
  endtask

  function automatic bit exp_ready(input int d);
    return (d == 1) || !m_valid[d][sel] || out_ready[sel];
  endfunction

  task automatic check_outputs(input string tag);
    logic [8*W-1:0] ed;
    logic [7:0]     ev, eo;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) begin
        ed[i*W +: W] = m_data[d][i];
        ev[i] = m_valid[d][i];
        eo[i] = m_ovr[d][i];
      end
      if (d == 0) begin
        chk({tag, "_s_dout"}, dout_s, ed);
        chk({tag, "_s_valid"}, {248'd0, ov_s}, {248'd0, ev});
        chk({tag, "_s_ovr"}, {248'd0, ovr_s}, {248'd0, eo});
        chk({tag, "_s_cnt"}, {240'd0, cnt_s}, {240'd0, 16'(m_cnt[0])});
      end else begin
        chk({tag, "_l_dout"}, dout_l, ed);
        chk({tag, "_l_valid"}, {248'd0, ov_l}, {248'd0, ev});
        chk({tag, "_l_ovr"}, {248'd0, ovr_l}, {248'd0, eo});
        chk({tag, "_l_cnt"}, {240'd0, cnt_l}, {240'd0, 16'(m_cnt[1])});
      end
    end
  endtask

  // Inputs are expected to be set just after a rising edge; one clock is applied.
  task automatic cycle(input string tag, input bit do_chk);
    bit rd;
    bit acc;
    #1;
    if (do_chk) begin
      chk({tag, "_s_rdy"}, {255'd0, rdy_s}, {255'd0, exp_ready(0)});
      chk({tag, "_l_rdy"}, {255'd0, rdy_l}, {255'd0, exp_ready(1)});
    end
    for (int d = 0; d < 2; d++) begin
      rd = exp_ready(d);
      for (int i = 0; i < 8; i++) begin
        acc = in_valid && rd && (sel == 3'(i));
        if (acc && d == 1 && m_valid[d][i] && !out_ready[i]) begin
          m_ovr[d][i] = 1'b1;
        end else if (clr_ovr[i]) begin
          m_ovr[d][i] = 1'b0;
        end
        if (acc) begin
          m_data[d][i]  = din;
          m_valid[d][i] = 1'b1;
        end else if (m_valid[d][i] && out_ready[i]) begin
          m_valid[d][i] = 1'b0;
        end
      end
      if (in_valid && rd) m_cnt[d] = (m_cnt[d] + 1) % 65536;
    end
    @(posedge clk);
    #1;
    if (do_chk) check_outputs(tag);
  endtask

  task automatic drive(input bit v, input logic [2:0] s, input logic [W-1:0] d,
                       input logic [7:0] rdy, input logic [7:0] clr);
    in_valid = v; sel = s; din = d; out_ready = rdy; clr_ovr = clr;
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    drive(1'b0, 3'd0, '0, 8'h00, 8'h00);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("por");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill every channel, then reset asynchronously mid-cycle
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 32'h1000_0000 + 32'(i), 8'h00, 8'h00);
      cycle("fill", 1'b1);
    end
    chk("fill_valid", {248'd0, ov_s}, {248'd0, 8'hFF});
    drive(1'b0, 3'd0, '0, 8'h00, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("areset");
    chk("areset_valid", {248'd0, ov_l}, 256'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle("post_reset", 1'b1);

    // Basic steer to channel 5, then drain
    drive(1'b1, 3'd5, 32'hDEADBEEF, 8'h00, 8'h00);
    cycle("basic", 1'b1);
    chk("basic_valid", {248'd0, ov_s}, {248'd0, 8'h20});
    chk("basic_data", {224'd0, dout_s[5*W +: W]}, {224'd0, 32'hDEADBEEF});
    drive(1'b0, 3'd0, '0, 8'h20, 8'h00);
    cycle("drain", 1'b1);
    chk("drain_valid", {248'd0, ov_s}, 256'd0);

    // Stall on full channel 2, other channel still accepted
    drive(1'b1, 3'd2, 32'h0000_2222, 8'h00, 8'h00);
    cycle("fill2", 1'b1);
    drive(1'b1, 3'd2, 32'h0BAD_0BAD, 8'h00, 8'h00);
    #1;
    chk("stall_rdy", {255'd0, rdy_s}, 256'd0);
    cycle("stall", 1'b1);
    chk("stall_data", {224'd0, dout_s[2*W +: W]}, {224'd0, 32'h0000_2222});
    drive(1'b1, 3'd3, 32'h0000_3333, 8'h00, 8'h00);
    cycle("other", 1'b1);
    chk("other_data", {224'd0, dout_s[3*W +: W]}, {224'd0, 32'h0000_3333});

    // Drain and refill channel 2 in the same cycle
    drive(1'b1, 3'd2, 32'h12345678, 8'h04, 8'h00);
    cycle("refill", 1'b1);
    chk("refill_valid", {255'd0, ov_s[2]}, {255'd0, 1'b1});
    chk("refill_data", {224'd0, dout_s[2*W +: W]}, {224'd0, 32'h12345678});

    // Overrun on channel 7, set beats clear, then clear alone
    drive(1'b1, 3'd7, 32'h7777_7777, 8'h00, 8'h00);
    cycle("ovr_fill", 1'b1);
    drive(1'b1, 3'd7, 32'hA5A5A5A5, 8'h00, 8'h00);
    cycle("ovr1", 1'b1);
    chk("ovr1_flag", {255'd0, ovr_l[7]}, {255'd0, 1'b1});
    chk("ovr1_data", {224'd0, dout_l[7*W +: W]}, {224'd0, 32'hA5A5A5A5});
    drive(1'b1, 3'd7, 32'h5A5A5A5A, 8'h00, 8'h80);
    cycle("ovr2", 1'b1);
    chk("ovr2_flag", {255'd0, ovr_l[7]}, {255'd0, 1'b1});
    drive(1'b0, 3'd0, '0, 8'h00, 8'h80);
    cycle("ovr_clr", 1'b1);
    chk("ovr_clr_flag", {255'd0, ovr_l[7]}, 256'd0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
            8'($urandom), ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00);
      cycle("rand", 1'b1);
    end

    // Counter wrap on the strict instance
    guard = 0;
    drive(1'b1, 3'd0, '0, 8'hFF, 8'h00);
    while (m_cnt[0] != 32'hFFFF && guard < 70000) begin
      sel = 3'($urandom_range(0, 7));
      din = $urandom;
      cycle("bulk", 1'b0);
      guard++;
    end
    check_outputs("preload");
    chk("preload_cnt", {240'd0, cnt_s}, {240'd0, 16'hFFFF});
    cycle("wrap", 1'b1);
    chk("wrap_cnt", {240'd0, cnt_s}, 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
